// File: rtl/step_pulse_gen_pkg.sv
// Shared definitions for the single-step pulse generator: key FSM encoding and width helper.
package step_pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        HELD    = 2'd2,
        LOCKOUT = 2'd3
    } key_state_t;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int width_of(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/step_rate_div.sv
// Free-run step divider: counts 0..RUN_DIV-1 while enabled, held at 0 otherwise.
module step_rate_div
    import step_pulse_gen_pkg::*;
#(
    parameter int RUN_DIV = 25000000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int DIV_W = width_of(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign tick = enable && (div_cnt == DIV_LAST);

    always_ff @(posedge clk_sys) begin
        if (!reset || !enable) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/step_pulse_gen.sv
// Turns debounced key presses (or the run-mode divider) into one-cycle CPU step enables.
//   state   | meaning
//   IDLE    | key released and lockout done; next press is accepted
//   PRESS   | press just accepted; single cycle, step pulse issued in manual mode
//   HELD    | key still down; no further pulses
//   LOCKOUT | key released; counting released cycles before re-arming
module step_pulse_gen
    import step_pulse_gen_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = 16,
    parameter int RUN_DIV        = 25000000,
    parameter int CNT_W          = 16
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             debkey,
    input  logic             run_mode,
    output logic             cpu_step,
    output logic [CNT_W-1:0] step_count,
    output logic             key_busy
);

    localparam int LOCK_W = width_of(LOCKOUT_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

    key_state_t       state;
    logic [LOCK_W-1:0] lock_cnt;
    logic             run_tick;
    logic             step_next;

    step_rate_div #(
        .RUN_DIV (RUN_DIV)
    ) u_rate_div (
        .clk_sys (clk_sys),
        .reset   (reset),
        .enable  (run_mode),
        .tick    (run_tick)
    );

    // The !cpu_step term stops a divider tick and a fresh key press from
    // producing back-to-back pulses across a run_mode change.
    always_comb begin
        step_next = 1'b0;
        if (run_mode) begin
            step_next = run_tick;
        end else begin
            step_next = (state == IDLE) && !debkey && !cpu_step;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            state      <= IDLE;
            lock_cnt   <= '0;
            cpu_step   <= 1'b0;
            step_count <= '0;
            key_busy   <= 1'b0;
        end else begin
            cpu_step   <= step_next;
            step_count <= step_count + CNT_W'(step_next);
            case (state)
                IDLE: begin
                    key_busy <= 1'b0;
                    if (!debkey) begin
                        state <= PRESS;
                    end
                end
                PRESS: begin
                    key_busy <= 1'b1;
                    state    <= HELD;
                end
                HELD: begin
                    key_busy <= 1'b1;
                    if (debkey) begin
                        lock_cnt <= '0;
                        state    <= LOCKOUT;
                    end
                end
                LOCKOUT: begin
                    if (!debkey) begin
                        lock_cnt <= '0;
                        state    <= HELD;
                    end else if (lock_cnt == LOCK_LAST) begin
                        lock_cnt <= '0;
                        key_busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: begin
                    key_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen: expected pulses queued at stimulus time, checked every cycle.
module tb_step_pulse_gen;

    localparam int LOCK = 4;
    localparam int DIV  = 5;
    localparam int CW   = 4;

    logic          clk_sys;
    logic          reset;
    logic          debkey;
    logic          run_mode;
    logic          cpu_step;
    logic [CW-1:0] step_count;
    logic          key_busy;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   model_cnt = 0;
    int   n_checks  = 0;
    int   n_pass    = 0;

    step_pulse_gen #(
        .LOCKOUT_CYCLES (LOCK),
        .RUN_DIV        (DIV),
        .CNT_W          (CW)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .debkey     (debkey),
        .run_mode   (run_mode),
        .cpu_step   (cpu_step),
        .step_count (step_count),
        .key_busy   (key_busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // A press or tick sampled at the next edge shows as cpu_step during cycle cyc+1.
    task automatic expect_step_at(input int c);
        model_cnt = (model_cnt + 1) % (1 << CW);
        sb.push_back('{cyc: c, cnt: model_cnt});
    endtask

    task automatic expect_step();
        expect_step_at(cyc + 1);
    endtask

    always @(negedge clk_sys) begin : monitor
        logic exp_step;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("pulse_missed", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        exp_step = (sb.size() > 0) && (sb[0].cyc == cyc);
        chk("cpu_step", cpu_step, exp_step);
        if (exp_step) begin
            chk("count_at_pulse", step_count, sb[0].cnt);
            void'(sb.pop_front());
        end
    end

    initial begin
        int r;
        reset    = 1'b0;
        debkey   = 1'b0;
        run_mode = 1'b0;

        tick(3);
        chk("rst_cpu_step", cpu_step, 0);
        chk("rst_step_count", step_count, 0);
        chk("rst_key_busy", key_busy, 0);

        // Release reset with the key already down: first press accepted.
        reset = 1'b1;
        expect_step();
        tick(1);
        chk("press_busy", key_busy, 0);
        tick(1);
        chk("held_busy", key_busy, 1);
        chk("single_count", step_count, 1);
        tick(98);

        // Release, bounce at released cycle 2, then full release.
        debkey = 1'b1;
        tick(2);
        chk("lockout_busy", key_busy, 1);
        debkey = 1'b0;
        tick(1);
        chk("bounce_busy", key_busy, 1);
        tick(4);
        chk("bounce_count", step_count, 1);
        debkey = 1'b1;
        for (int i = 1; i <= LOCK + 1; i++) begin
            tick(1);
            chk("lock_busy", key_busy, (i <= LOCK));
        end

        debkey = 1'b0;
        expect_step();
        tick(2);
        chk("second_count", step_count, 2);
        tick(3);
        debkey = 1'b1;
        tick(6);

        // Free-run: pulses at 5, 10, 15, 20 cycles after the rise; key ignored.
        run_mode = 1'b1;
        r = cyc;
        for (int k = 1; k <= 4; k++) expect_step_at(r + k * DIV);
        tick(6);
        debkey = 1'b0;
        tick(3);
        chk("run_key_busy", key_busy, 1);
        debkey = 1'b1;
        tick(14);
        run_mode = 1'b0;
        tick(10);
        chk("run_count", step_count, 6);

        // Reset while HELD.
        debkey = 1'b0;
        expect_step();
        tick(5);
        chk("pre_rst_busy", key_busy, 1);
        reset = 1'b0;
        tick(1);
        chk("rst_held_busy", key_busy, 0);
        chk("rst_held_count", step_count, 0);
        model_cnt = 0;
        reset = 1'b1;
        expect_step();
        tick(4);
        debkey = 1'b1;
        tick(2);
        chk("pre_rst_lock_busy", key_busy, 1);

        // Reset while LOCKOUT; next press must pulse with no lockout left.
        reset = 1'b0;
        tick(1);
        chk("rst_lock_busy", key_busy, 0);
        chk("rst_lock_count", step_count, 0);
        model_cnt = 0;
        reset  = 1'b1;
        debkey = 1'b0;
        expect_step();
        tick(3);
        debkey = 1'b1;
        tick(6);
        chk("post_rst_count", step_count, 1);

        // Counter wrap from zero over 17 presses.
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        model_cnt = 0;
        for (int i = 1; i <= 17; i++) begin
            debkey = 1'b0;
            expect_step();
            tick(2);
            debkey = 1'b1;
            tick(6);
            if (i >= 15) chk("wrap_count", step_count, i % 16);
        end

        tick(3);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
